// File: rtl/usb_pkg.sv
// Shared USB constants: buffer depth, packet types and their PID encodings.
package usb_pkg;

  localparam int USB_BUF_DEPTH = 64;

  typedef enum logic [2:0] {
    OUT,
    IN,
    DATA0,
    DATA1,
    ACK,
    NAK,
    STALL
  } tx_packet_type;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  function automatic logic [3:0] pid_of(input tx_packet_type t);
    case (t)
      OUT:     return PID_OUT;
      IN:      return PID_IN;
      DATA0:   return PID_DATA0;
      DATA1:   return PID_DATA1;
      ACK:     return PID_ACK;
      NAK:     return PID_NAK;
      default: return PID_STALL;
    endcase
  endfunction

endpackage

// File: rtl/usb_buffer_ctrl.sv
// Read/write pointers, occupancy and overflow/underflow flags for the shared
// packet FIFO. Pointers carry one extra wrap bit so full and empty differ.
module usb_buffer_ctrl
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_BUF_DEPTH,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [OCC_W-1:0] wptr_o,
  output logic [OCC_W-1:0] rptr_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             push_ok_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [OCC_W-1:0] wptr_q, wptr_d;
  logic [OCC_W-1:0] rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty, do_push, do_pop;

  assign occupancy_o = wptr_q - rptr_q;
  assign full        = (occupancy_o == OCC_W'(DEPTH));
  assign empty       = (occupancy_o == '0);

  // A pop frees the slot the same edge, so a full buffer still accepts a push.
  assign do_push = push_i & ~clear_i & (~full | pop_i);
  assign do_pop  = pop_i & ~clear_i & ~empty;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + OCC_W'(1);
      if (do_pop)  rptr_d = rptr_q + OCC_W'(1);
      ovf_d = push_i & full & ~pop_i;
      unf_d = pop_i & empty;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign wptr_o      = wptr_q;
  assign rptr_o      = rptr_q;
  assign push_ok_o   = do_push;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/usb_data_buffer.sv
// Shared 64-byte first-word-fall-through packet buffer between the host side
// and the USB TX/RX engines; only one direction is active at a time.
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_BUF_DEPTH,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_rx_data,
  output logic [7:0]       rx_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = OCC_W - 1;

  logic [7:0]       mem [DEPTH];
  logic [OCC_W-1:0] wptr, rptr;
  logic             push, pop, push_ok;
  logic [7:0]       wdata, head;
  logic             unused_wrap_bits;

  assign push  = store_rx_packet_data | store_tx_data;
  assign pop   = get_tx_packet_data | get_rx_data;
  // RX engine wins when both sides push in the same cycle.
  assign wdata = store_rx_packet_data ? rx_packet_data : tx_data;

  usb_buffer_ctrl #(
    .DEPTH(DEPTH),
    .OCC_W(OCC_W)
  ) u_ctrl (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear_i    (clear),
    .push_i     (push),
    .pop_i      (pop),
    .wptr_o     (wptr),
    .rptr_o     (rptr),
    .occupancy_o(buffer_occupancy),
    .push_ok_o  (push_ok),
    .overflow_o (overflow),
    .underflow_o(underflow)
  );

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  assign head           = (buffer_occupancy == '0) ? 8'h00 : mem[rptr[AW-1:0]];
  assign tx_packet_data = head;
  assign rx_data        = head;

  assign unused_wrap_bits = wptr[AW] ^ rptr[AW];

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: a constant vector table for the
// short cases and a queue reference model for the long streams.
module tb_usb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear, store_tx_data, get_tx_packet_data;
  logic       store_rx_packet_data, get_rx_data;
  logic [7:0] tx_data, rx_packet_data;
  logic [7:0] tx_packet_data, rx_data;
  logic [6:0] buffer_occupancy;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic       clr;
    logic       stx;
    logic [7:0] txd;
    logic       gtx;
    logic       srx;
    logic [7:0] rxd;
    logic       grx;
    logic [6:0] occ;
    logic [7:0] head;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[10];

  usb_data_buffer #(.DEPTH(64), .OCC_W(7)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .clear               (clear),
    .store_tx_data       (store_tx_data),
    .tx_data             (tx_data),
    .get_tx_packet_data  (get_tx_packet_data),
    .tx_packet_data      (tx_packet_data),
    .store_rx_packet_data(store_rx_packet_data),
    .rx_packet_data      (rx_packet_data),
    .get_rx_data         (get_rx_data),
    .rx_data             (rx_data),
    .buffer_occupancy    (buffer_occupancy),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    clear = 0; store_tx_data = 0; tx_data = 8'h00; get_tx_packet_data = 0;
    store_rx_packet_data = 0; rx_packet_data = 8'h00; get_rx_data = 0;
  endtask

  // One clock of stimulus: check head against the model before the edge,
  // update the model, then check occupancy and flags after the edge.
  task automatic step(input logic clr, input logic stx, input logic [7:0] txd,
                      input logic gtx, input logic srx, input logic [7:0] rxd,
                      input logic grx);
    logic [7:0] exp_head, d;
    logic push, pop, full, empty, eo, eu;
    @(negedge clk);
    clear = clr; store_tx_data = stx; tx_data = txd; get_tx_packet_data = gtx;
    store_rx_packet_data = srx; rx_packet_data = rxd; get_rx_data = grx;
    exp_head = (sb_q.size() != 0) ? sb_q[0] : 8'h00;
    #1;
    check("head_tx", 32'(tx_packet_data), 32'(exp_head));
    check("head_rx", 32'(rx_data), 32'(exp_head));
    push  = srx | stx;
    pop   = gtx | grx;
    d     = srx ? rxd : txd;
    full  = (sb_q.size() == 64);
    empty = (sb_q.size() == 0);
    if (clr) begin
      sb_q.delete();
      eo = 0;
      eu = 0;
    end else begin
      eo = push & full & ~pop;
      eu = pop & empty;
      if (pop && !empty) void'(sb_q.pop_front());
      if (push && (!full || pop)) sb_q.push_back(d);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check("occupancy", 32'(buffer_occupancy), 32'(sb_q.size()));
    check("overflow", 32'(overflow), 32'(eo));
    check("underflow", 32'(underflow), 32'(eu));
  endtask

  task automatic push_tx(input logic [7:0] d);
    step(0, 1, d, 0, 0, 8'h00, 0);
  endtask

  task automatic pop_tx();
    step(0, 0, 8'h00, 1, 0, 8'h00, 0);
  endtask

  initial begin
    idle_inputs();
    n_rst = 1'b0;

    vecs[0] = '{0, 1, 8'h7C, 0, 0, 8'h00, 0, 7'd1, 8'h7C, 0, 0};
    vecs[1] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 7'd0, 8'h00, 0, 0};
    vecs[2] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 7'd0, 8'h00, 0, 1};
    vecs[3] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 7'd0, 8'h00, 0, 0};
    vecs[4] = '{0, 1, 8'hAA, 1, 0, 8'h00, 0, 7'd1, 8'hAA, 0, 1};
    vecs[5] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 7'd0, 8'h00, 0, 0};
    vecs[6] = '{0, 1, 8'h44, 0, 1, 8'h33, 0, 7'd1, 8'h33, 0, 0};
    vecs[7] = '{0, 0, 8'h00, 0, 1, 8'h66, 0, 7'd2, 8'h33, 0, 0};
    vecs[8] = '{0, 0, 8'h00, 1, 0, 8'h00, 1, 7'd1, 8'h66, 0, 0};
    vecs[9] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 7'd0, 8'h00, 0, 0};

    #12;
    check("reset_occ", 32'(buffer_occupancy), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_unf", 32'(underflow), 32'd0);
    check("reset_tx", 32'(tx_packet_data), 32'h00);
    check("reset_rx", 32'(rx_data), 32'h00);
    @(negedge clk);
    n_rst = 1'b1;

    // Constant-expectation vectors: single push/pop, underflow, push+pop on
    // empty, RX-over-TX push priority, dual pop removes one byte.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].clr, vecs[i].stx, vecs[i].txd, vecs[i].gtx,
           vecs[i].srx, vecs[i].rxd, vecs[i].grx);
      check($sformatf("vec%0d_occ", i), 32'(buffer_occupancy), 32'(vecs[i].occ));
      check($sformatf("vec%0d_head", i), 32'(tx_packet_data), 32'(vecs[i].head));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
    end

    // Fill 01..40, overflow on the 65th push, drain in order.
    for (int i = 1; i <= 64; i++) push_tx(8'(i));
    check("full_occ", 32'(buffer_occupancy), 32'd64);
    push_tx(8'hEE);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_occ", 32'(buffer_occupancy), 32'd64);
    step(0, 0, 8'h00, 0, 0, 8'h00, 0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 64; i++) pop_tx();
    check("drain_occ", 32'(buffer_occupancy), 32'd0);

    // Wrap across address 63 -> 0.
    for (int i = 0; i < 40; i++) push_tx(8'(8'h80 + i));
    for (int i = 0; i < 40; i++) pop_tx();
    for (int i = 0; i < 30; i++) push_tx(8'(8'hC0 + i));
    for (int i = 0; i < 30; i++) pop_tx();
    check("wrap_occ", 32'(buffer_occupancy), 32'd0);

    // Full buffer with simultaneous push and pop keeps occupancy at 64.
    for (int i = 0; i < 64; i++) step(0, 0, 8'h00, 0, 1, 8'(8'h10 + i), 0);
    step(0, 1, 8'h55, 1, 0, 8'h00, 0);
    check("full_pp_occ", 32'(buffer_occupancy), 32'd64);
    for (int i = 0; i < 63; i++) step(0, 0, 8'h00, 0, 0, 8'h00, 1);
    check("last_byte", 32'(tx_packet_data), 32'h55);
    pop_tx();

    // Clear with a simultaneous push discards everything.
    for (int i = 0; i < 10; i++) push_tx(8'(8'h20 + i));
    step(1, 1, 8'h99, 0, 0, 8'h00, 0);
    check("clear_occ", 32'(buffer_occupancy), 32'd0);
    check("clear_head", 32'(tx_packet_data), 32'h00);
    push_tx(8'h12);
    check("post_clear_head", 32'(tx_packet_data), 32'h12);
    pop_tx();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 5; i++) push_tx(8'(8'h30 + i));
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_occ", 32'(buffer_occupancy), 32'd0);
    check("async_rst_head", 32'(tx_packet_data), 32'h00);
    sb_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    push_tx(8'h5A);
    pop_tx();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

Shared 64-byte FIFO packet buffer between the endpoint/host-side interface and the USB serial engines. On the transmit path it sits directly upstream of the bit-stuffing NRZI transmitter: it supplies `tx_packet_data` and `buffer_occupancy`, and it pops one byte per `get_tx_packet_data` pulse. On the receive path the RX engine pushes decoded bytes in, and the host side drains them. A single read pointer and a single write pointer are shared by both directions, because only one transfer direction is active at a time.

## Interface
Parameters:
- `DEPTH`, 64: byte capacity; must be a power of two.
- `OCC_W`, 7: occupancy width, equal to $clog2(DEPTH)+1.

Ports:
- `clk`  in  1  system clock (100 MHz)
- `n_rst`  in  1  reset; one clock, asynchronous, active-low
- `clear`  in  1  synchronous flush; empties the buffer
- `store_tx_data`  in  1  host-side push of `tx_data`
- `tx_data`  in  8  host-side byte to transmit
- `get_tx_packet_data`  in  1  TX engine pop request (one-cycle pulse)
- `tx_packet_data`  out  8  head byte presented to the TX engine (first-word fall-through)
- `store_rx_packet_data`  in  1  RX engine push of `rx_packet_data`
- `rx_packet_data`  in  8  decoded received byte
- `get_rx_data`  in  1  host-side pop request
- `rx_data`  out  8  head byte presented to the host side
- `buffer_occupancy`  out  OCC_W  number of valid bytes, 0..64
- `overflow`  out  1  one-cycle pulse when a push is dropped
- `underflow`  out  1  one-cycle pulse when a pop is dropped

## Operation
Storage and pointers:
- Storage is `DEPTH` x 8 memory addressed by `wptr` and `rptr`. Each pointer is OCC_W bits wide; the low bits form the address and the MSB is a wrap flag.
- `buffer_occupancy` = `wptr - rptr`, computed modulo 2^OCC_W.
- Full is occupancy == 64. Empty is occupancy == 0.

Push and pop:
- Push = `store_rx_packet_data | store_tx_data`. When both are asserted, `rx_packet_data` is written and `tx_data` is ignored; no error is flagged.
- Pop = `get_tx_packet_data | get_rx_data`. Asserting both in one cycle pops one byte only.

Priority, highest first:
1. `clear`: both pointers are set to 0, and any push or pop in the same cycle is discarded.
2. Push and pop.

Full, empty and simultaneous events:
- Push while full with no pop: the push is dropped, the data is unchanged and `overflow` pulses.
- Push while full with a pop: both occur and occupancy stays at 64.
- Pop while empty with no push: the pop is dropped and `underflow` pulses.
- Pop while empty with a push: the push occurs, the pop is dropped and `underflow` pulses. Occupancy becomes 1.
- Push and pop otherwise: both occur and occupancy is unchanged.

Outputs:
- `tx_packet_data` and `rx_data` are both equal to `mem[rptr]` when not empty, and 8'h00 when empty.
- Pointers wrap naturally from address 63 to 0, with the wrap flag toggling.
- Memory contents are not reset. Only the pointers and flags are reset.

## Timing
- Reset values: `wptr`=0, `rptr`=0, `buffer_occupancy`=0, `overflow`=0, `underflow`=0, and `tx_packet_data`/`rx_data`=8'h00.
- A push on rising edge N is reflected in `buffer_occupancy` after edge N. If the buffer was empty, the byte appears on `tx_packet_data` in the same cycle, giving zero extra latency.
- A pop on edge N advances the head after edge N. The TX engine samples `tx_packet_data` in the cycle it asserts `get_tx_packet_data`.
- Pops may occur on back-to-back cycles. A push and a pop may occur in the same cycle.
- `overflow` and `underflow` are registered and high for exactly the cycle after the offending edge.
- Asserting `n_rst` mid-transfer empties the buffer immediately, asynchronously.

## Structure
- Constants go in the shared `usb_pkg` package:
  - `USB_BUF_DEPTH` = 64.
  - The `tx_packet_type` enum (OUT, IN, DATA0, DATA1, ACK, NAK, STALL).
  - The PID constants.
- The pointer, occupancy and flag logic goes in one sub-module, `usb_buffer_ctrl`. Its interface is push/pop/clear in, and `wptr`, `rptr`, occupancy and error flags out.
- The memory array and output muxing stay in `usb_data_buffer`.

## Test plan
- Reset, then push 8'h7C via `store_tx_data` -> occupancy 1 and `tx_packet_data`=8'h7C in the next cycle; one `get_tx_packet_data` pulse -> occupancy 0 and `tx_packet_data`=8'h00.
- Push 8'h01..8'h40 (64 bytes) -> occupancy 64. A 65th push -> `overflow` pulses and occupancy stays 64. Pop 64 bytes -> bytes read out as 01..40 in order.
- When empty, pulse `get_tx_packet_data` -> `underflow` pulses and occupancy stays 0. Simultaneous push of 8'hAA and pop -> occupancy 1, head 8'hAA, `underflow` pulses.
- Wrap test: 40 pushes then 40 pops, followed by 30 pushes and 30 pops -> data ordering is correct across the address 63->0 wrap, and occupancy is 0 at the end.
- With occupancy 64, push 8'h55 and pop in the same cycle -> occupancy stays 64, and 8'h55 is read last.
- With 10 bytes stored, `clear` together with a push -> occupancy is 0 in the next cycle and the pushed byte is discarded. Asserting `n_rst` mid-stream -> occupancy is 0 immediately.
